phy_rx_deframer: RTL

//  Receive-side counterpart of the transmit PHY path: takes the 4-bit MII-style nibble stream from the PHY.
//  - Strips preamble/SFD; packs nibbles (low nibble first) into bytes.
//  - Delivers bytes to the receive buffer; emits an end-of-frame control word in the same 24-bit format the

---
 rtl/phy_rx_deframer_pkg.sv | 37 +++
 rtl/phy_rx_deframer_if.sv | 23 ++
 rtl/phy_rx_nibble_packer.sv | 45 ++++
 rtl/phy_rx_deframer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/phy_rx_deframer_pkg.sv
// Shared definitions for the receive deframer: FSM states, preamble/SFD
// nibble codes, widths and the 24-bit end-of-frame control word.
package phy_rx_deframer_pkg;

  localparam int unsigned NIB_W      = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LEN_W      = 13;
  localparam int unsigned CTRL_LEN_W = 12;
  localparam int unsigned CTRL_W     = 2 * CTRL_LEN_W;
  localparam int unsigned PRE_CNT_W  = 4;

  localparam logic [NIB_W-1:0]     NIB_PRE = 4'h5;
  localparam logic [NIB_W-1:0]     NIB_SFD = 4'hD;
  localparam logic [LEN_W-1:0]     LEN_SAT = 13'd4095;
  localparam logic [PRE_CNT_W-1:0] PRE_SAT = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_e;

  // [23:12] and [11:0] both carry the byte count
  typedef struct packed {
    logic [CTRL_LEN_W-1:0] len_hi;
    logic [CTRL_LEN_W-1:0] len_lo;
  } rx_ctrl_t;

  function automatic rx_ctrl_t make_ctrl(input logic [CTRL_LEN_W-1:0] len);
    rx_ctrl_t c;
    c.len_hi = len;
    c.len_lo = len;
    return c;
  endfunction

endpackage

// File: rtl/phy_rx_deframer_if.sv
// PHY nibble input and receive-buffer output bundle of the deframer.
interface phy_rx_deframer_if;
  import phy_rx_deframer_pkg::*;

  logic [NIB_W-1:0]  phy_data_in;
  logic              phy_rx_dv;
  logic [BYTE_W-1:0] r_data_out;
  logic              r_data_valid;
  logic              r_frame_valid;
  logic [CTRL_W-1:0] r_ctrl_out;
  logic              r_hi_priority;
  logic              r_frame_err;

  modport master (
    output phy_data_in, phy_rx_dv,
    input  r_data_out, r_data_valid, r_frame_valid, r_ctrl_out, r_hi_priority, r_frame_err
  );

  modport slave (
    input  phy_data_in, phy_rx_dv,
    output r_data_out, r_data_valid, r_frame_valid, r_ctrl_out, r_hi_priority, r_frame_err
  );
endinterface

// File: rtl/phy_rx_nibble_packer.sv
// Packs low-nibble-first nibble pairs into bytes; registered byte and strobe,
// plus the current phase (odd) and a same-cycle byte-complete indication.
module phy_rx_nibble_packer
  import phy_rx_deframer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              nib_valid,
  input  logic [NIB_W-1:0]  nib,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_stb,
  output logic              odd,
  output logic              byte_done_c
);

  logic [NIB_W-1:0] low_q;

  assign byte_done_c = nib_valid & odd;

  always_ff @(posedge clk) begin
    if (reset) begin
      odd       <= 1'b0;
      low_q     <= '0;
      byte_data <= '0;
      byte_stb  <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      if (clr) begin
        odd   <= 1'b0;
        low_q <= '0;
      end else if (nib_valid) begin
        if (odd) begin
          byte_data <= {nib, low_q};
          byte_stb  <= 1'b1;
          odd       <= 1'b0;
        end else begin
          low_q <= nib;
          odd   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phy_rx_deframer.sv
// Receive deframer: strips preamble/SFD, hands bytes to the buffer and
// reports length, priority and error status at the end of each frame.
module phy_rx_deframer
  import phy_rx_deframer_pkg::*;
#(
  parameter int unsigned PRE_MIN = 7,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic               clk_phy,
  input  logic               reset,
  phy_rx_deframer_if.slave   rx
);

  rx_state_e            state;
  logic [PRE_CNT_W-1:0] pre_cnt;
  logic [LEN_W-1:0]     len;
  logic                 drop_report;
  logic                 frame_valid;
  logic                 frame_err;
  logic                 hi_priority;
  rx_ctrl_t             ctrl;

  logic                 dv;
  logic [NIB_W-1:0]     nib;
  logic                 sfd_ok_c;
  logic                 nib_valid_c;
  logic                 byte_done_c;
  logic                 odd;

  assign dv          = rx.phy_rx_dv;
  assign nib         = rx.phy_data_in;
  assign sfd_ok_c    = (state == ST_PRE) && dv && (nib == NIB_SFD)
                       && (pre_cnt >= PRE_CNT_W'(PRE_MIN));
  assign nib_valid_c = (state == ST_DATA) && dv;

  phy_rx_nibble_packer u_packer (
    .clk         (clk_phy),
    .reset       (reset),
    .clr         (sfd_ok_c),
    .nib_valid   (nib_valid_c),
    .nib         (nib),
    .byte_data   (rx.r_data_out),
    .byte_stb    (rx.r_data_valid),
    .odd         (odd),
    .byte_done_c (byte_done_c)
  );

  always_ff @(posedge clk_phy) begin
    if (reset) begin
      state       <= ST_IDLE;
      pre_cnt     <= '0;
      len         <= '0;
      drop_report <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      hi_priority <= 1'b0;
      ctrl        <= '0;
    end else begin
      frame_valid <= 1'b0;

      // byte completes this cycle: count it, sample priority from byte 0
      if (byte_done_c) begin
        if (len == '0) hi_priority <= nib[3];
        if (len != LEN_SAT) len <= len + LEN_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (dv) begin
            if (nib == NIB_PRE) begin
              state   <= ST_PRE;
              pre_cnt <= PRE_CNT_W'(1);
            end else begin
              state       <= ST_DROP;
              drop_report <= 1'b0;
            end
          end
        end

        ST_PRE: begin
          if (!dv) begin
            state <= ST_IDLE;
          end else if (nib == NIB_PRE) begin
            if (pre_cnt != PRE_SAT) pre_cnt <= pre_cnt + PRE_CNT_W'(1);
          end else if (sfd_ok_c) begin
            state <= ST_DATA;
            len   <= '0;
          end else begin
            state       <= ST_DROP;
            drop_report <= 1'b1;
          end
        end

        ST_DATA: begin
          if (!dv) begin
            frame_valid <= 1'b1;
            frame_err   <= odd || (len < LEN_W'(MIN_LEN)) || (len > LEN_W'(MAX_LEN));
            ctrl        <= make_ctrl(CTRL_LEN_W'(len));
            state       <= ST_IDLE;
          end
        end

        ST_DROP: begin
          if (!dv) begin
            if (drop_report) begin
              frame_valid <= 1'b1;
              frame_err   <= 1'b1;
              ctrl        <= '0;
            end
            len   <= '0;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rx.r_frame_valid = frame_valid;
  assign rx.r_frame_err   = frame_err;
  assign rx.r_hi_priority = hi_priority;
  assign rx.r_ctrl_out    = ctrl;

endmodule
